// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_fetch_ctrl : MIPS IF-stage controller (PC, IF/ID register, fetch control)
// Revision: 1.0
// ----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] EXC_PC   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PCPlus4,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic        FetchFault,
    output logic [31:0] FaultPC
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [5:0] OPC_J = 6'b000010;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halted_q, halted_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic        is_self_jump;
    logic        redirect_aligned;
    logic        do_bubble;
    logic        do_latch;

    assign pc_plus4         = pc_q + 32'd4;
    assign jump_target      = {pc_q[31:28], ImemInstruction[25:0], 2'b00};
    assign is_self_jump     = (ImemInstruction[31:26] == OPC_J) && (jump_target == pc_q);
    assign redirect_aligned = (RedirectPC[1:0] == 2'b00);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        halted_d      = halted_q;
        fetch_fault_d = 1'b0;
        fault_pc_d    = fault_pc_q;
        do_bubble     = 1'b0;
        do_latch      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                do_bubble = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (Redirect) begin
                    do_bubble = 1'b1;
                    if (redirect_aligned) begin
                        pc_d = RedirectPC;
                    end else begin
                        pc_d          = EXC_PC;
                        fetch_fault_d = 1'b1;
                        fault_pc_d    = RedirectPC;
                    end
                end else if (Flush) begin
                    do_bubble = 1'b1;
                    if (!Stall) begin
                        pc_d = pc_plus4;
                    end
                end else if (!Stall) begin
                    do_latch = 1'b1;
                    // The halting jump is still delivered downstream; only the PC freezes.
                    if (is_self_jump) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_HALT: begin
                do_bubble = 1'b1;
                if (Redirect) begin
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                    if (redirect_aligned) begin
                        pc_d = RedirectPC;
                    end else begin
                        pc_d          = EXC_PC;
                        fetch_fault_d = 1'b1;
                        fault_pc_d    = RedirectPC;
                    end
                end
            end
            default: begin
                do_bubble = 1'b1;
                state_d   = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (do_bubble) begin
            ifid_pc_d    = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
        end else if (do_latch) begin
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = ImemInstruction;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= 32'h0;
            ifid_pc4_q    <= 32'h0;
            ifid_instr_q  <= 32'h0;
            ifid_valid_q  <= 1'b0;
            halted_q      <= 1'b0;
            fetch_fault_q <= 1'b0;
            fault_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            halted_q      <= halted_d;
            fetch_fault_q <= fetch_fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign ImemAddress       = pc_q;
    assign IF_ID_PC          = ifid_pc_q;
    assign IF_ID_PCPlus4     = ifid_pc4_q;
    assign IF_ID_Instruction = ifid_instr_q;
    assign IF_ID_Valid       = ifid_valid_q;
    assign Halted            = halted_q;
    assign FetchFault        = fetch_fault_q;
    assign FaultPC           = fault_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_inst_fetch_ctrl : directed self-checking bench for inst_fetch_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PCPlus4;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_Valid;
    logic        Halted;
    logic        FetchFault;
    logic [31:0] FaultPC;

    int n_total = 0;
    int n_bad   = 0;

    inst_fetch_ctrl #(
        .RESET_PC (32'h0040_0000),
        .EXC_PC   (32'h8000_0180)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .Redirect          (Redirect),
        .RedirectPC        (RedirectPC),
        .ImemAddress       (ImemAddress),
        .ImemInstruction   (ImemInstruction),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_Valid       (IF_ID_Valid),
        .Halted            (Halted),
        .FetchFault        (FetchFault),
        .FaultPC           (FaultPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency instruction memory; unlisted words read as nop.
    always_comb begin
        case (ImemAddress)
            32'h0040_0000: ImemInstruction = 32'h2004_2f5b;
            32'h0040_0004: ImemInstruction = 32'h2405_cfc7;
            32'h0040_0034: ImemInstruction = 32'h0810_000d;
            default:       ImemInstruction = 32'h0000_0000;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        Stall      = s;
        Flush      = f;
        Redirect   = r;
        RedirectPC = rpc;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid);
        check_val({tag, ".pc"}, IF_ID_PC, pc);
        check_val({tag, ".pc4"}, IF_ID_PCPlus4, valid ? pc + 32'd4 : 32'h0);
        check_val({tag, ".instr"}, IF_ID_Instruction, instr);
        check_val({tag, ".valid"}, {31'h0, IF_ID_Valid}, {31'h0, valid});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) tick();

        check_val("rst.addr", ImemAddress, 32'h0040_0000);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check_val("rst.halted", {31'h0, Halted}, 32'h0);
        check_val("rst.fault", {31'h0, FetchFault}, 32'h0);
        check_val("rst.faultpc", FaultPC, 32'h0);

        reset = 1'b1;
        // BOOT ignores inputs even if a redirect is requested
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0100);
        tick();
        check_ifid("boot", 32'h0, 32'h0, 1'b0);
        check_val("boot.addr", ImemAddress, 32'h0040_0000);
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        tick();
        check_ifid("f0", 32'h0040_0000, 32'h2004_2f5b, 1'b1);
        check_val("f0.addr", ImemAddress, 32'h0040_0004);
        tick();
        check_ifid("f1", 32'h0040_0004, 32'h2405_cfc7, 1'b1);
        check_val("f1.addr", ImemAddress, 32'h0040_0008);

        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall.addr", ImemAddress, 32'h0040_0008);
            check_ifid("stall", 32'h0040_0004, 32'h2405_cfc7, 1'b1);
        end

        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check_ifid("stflush", 32'h0, 32'h0, 1'b0);
        check_val("stflush.addr", ImemAddress, 32'h0040_0008);

        drive(1'b1, 1'b0, 1'b1, 32'h0040_0020);
        tick();
        check_val("redir.addr", ImemAddress, 32'h0040_0020);
        check_val("redir.valid", {31'h0, IF_ID_Valid}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_ifid("redir.f", 32'h0040_0020, 32'h0, 1'b1);
        check_val("redir.f.addr", ImemAddress, 32'h0040_0024);

        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_ifid("flush", 32'h0, 32'h0, 1'b0);
        check_val("flush.addr", ImemAddress, 32'h0040_0028);

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        check_val("pre_halt.addr", ImemAddress, 32'h0040_0034);
        check_val("pre_halt.halted", {31'h0, Halted}, 32'h0);
        tick();
        check_ifid("halt", 32'h0040_0034, 32'h0810_000d, 1'b1);
        check_val("halt.halted", {31'h0, Halted}, 32'h1);
        check_val("halt.addr", ImemAddress, 32'h0040_0034);

        for (int i = 0; i < 10; i++) begin
            drive(i[0], i[1], 1'b0, 32'h0);
            tick();
            check_val("halt.hold.addr", ImemAddress, 32'h0040_0034);
            check_val("halt.hold.halted", {31'h0, Halted}, 32'h1);
            check_ifid("halt.hold", 32'h0, 32'h0, 1'b0);
        end

        drive(1'b0, 1'b0, 1'b1, 32'h0040_0000);
        tick();
        check_val("unhalt.halted", {31'h0, Halted}, 32'h0);
        check_val("unhalt.addr", ImemAddress, 32'h0040_0000);
        check_ifid("unhalt", 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_ifid("unhalt.f", 32'h0040_0000, 32'h2004_2f5b, 1'b1);

        drive(1'b0, 1'b0, 1'b1, 32'h0040_0006);
        tick();
        check_val("mis.addr", ImemAddress, 32'h8000_0180);
        check_val("mis.fault", {31'h0, FetchFault}, 32'h1);
        check_val("mis.faultpc", FaultPC, 32'h0040_0006);
        check_val("mis.valid", {31'h0, IF_ID_Valid}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("mis2.fault", {31'h0, FetchFault}, 32'h0);
        check_val("mis2.faultpc", FaultPC, 32'h0040_0006);
        check_ifid("mis2", 32'h8000_0180, 32'h0, 1'b1);
        check_val("mis2.addr", ImemAddress, 32'h8000_0184);

        drive(1'b0, 1'b0, 1'b1, 32'h0040_0001);
        tick();
        check_val("b2b0.fault", {31'h0, FetchFault}, 32'h1);
        check_val("b2b0.faultpc", FaultPC, 32'h0040_0001);
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0003);
        tick();
        check_val("b2b1.fault", {31'h0, FetchFault}, 32'h1);
        check_val("b2b1.faultpc", FaultPC, 32'h0040_0003);
        check_val("b2b1.addr", ImemAddress, 32'h8000_0180);

        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        check_val("wrap.fault", {31'h0, FetchFault}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("wrap.pc", IF_ID_PC, 32'hFFFF_FFFC);
        check_val("wrap.pc4", IF_ID_PCPlus4, 32'h0);
        check_val("wrap.addr", ImemAddress, 32'h0);

        drive(1'b0, 1'b0, 1'b1, 32'h0040_000C);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_val("pre_rst.addr", ImemAddress, 32'h0040_0010);
        check_ifid("pre_rst", 32'h0040_000C, 32'h0, 1'b1);

        #2;
        reset = 1'b0;
        #1;
        check_val("arst.addr", ImemAddress, 32'h0040_0000);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        check_val("arst.halted", {31'h0, Halted}, 32'h0);
        check_val("arst.fault", {31'h0, FetchFault}, 32'h0);
        check_val("arst.faultpc", FaultPC, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        tick();
        check_ifid("boot2", 32'h0, 32'h0, 1'b0);
        check_val("boot2.addr", ImemAddress, 32'h0040_0000);
        tick();
        check_ifid("boot2.f", 32'h0040_0000, 32'h2004_2f5b, 1'b1);
        check_val("boot2.f.addr", ImemAddress, 32'h0040_0004);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
